// File: rtl/fetch_pkg.sv
// Shared types and constants for the two-hart instruction-fetch scheduler.
package fetch_pkg;

  // Fetch FSM states: pick a hart, present the request, wait for its response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // Hart identifier (two harts).
  typedef logic hart_t;

  // Default PCs loaded into each hart after reset.
  localparam logic [31:0] DEF_RESET_PC0 = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC1 = 32'h0000_1000;

  // Two-way round-robin: prefer the hart after 'last'; fall back to 'last'.
  // Callers qualify the result with |req.
  function automatic hart_t rr_pick(input hart_t last, input logic [1:0] req);
    hart_t pick;
    if (req[~last]) begin
      pick = ~last;
    end else begin
      pick = last;
    end
    return pick;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Per-hart FIFO of {instr, pc}. Flush has priority over push and pop.
// The caller only pushes into a full buffer when it pops in the same cycle.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_push_instr,
  input  logic [ADDR_W-1:0]      i_push_pc,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [DATA_W-1:0]      o_head_instr,
  output logic [ADDR_W-1:0]      o_head_pc,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_instr [DEPTH];
  logic [ADDR_W-1:0] r_pc    [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full       = (r_count == CNT_W'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign o_count      = r_count;
  assign o_head_instr = r_instr[r_rd_ptr];
  assign o_head_pc    = r_pc[r_rd_ptr];

  // Qualify push/pop: a flush suppresses both, pop needs a valid entry.
  always_comb begin
    w_do_push = i_push && !i_flush;
    w_do_pop  = i_pop && !o_empty && !i_flush;
  end

  // Storage, pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_instr[r_wr_ptr] <= i_push_instr;
        r_pc[r_wr_ptr]    <= i_push_pc;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_scheduler.sv
// Two-hart fetch scheduler: one outstanding fetch on a shared memory port,
// per-hart buffers drained round-robin to decode, per-hart branch redirects.
module fetch_scheduler
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC0 = ADDR_W'(DEF_RESET_PC0),
  parameter logic [ADDR_W-1:0] RESET_PC1 = ADDR_W'(DEF_RESET_PC1),
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic              redirect_hart,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_hart
);

  localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  fetch_state_e r_state, w_state_nxt;
  hart_t        r_hart, w_hart_nxt;
  hart_t        r_last_issue, w_last_issue_nxt;
  hart_t        r_last_pop;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic         r_kill, w_kill_nxt;
  logic [ADDR_W-1:0] r_pc [2];
  logic [ADDR_W-1:0] w_pc_nxt [2];
  logic         w_pc_inc;

  logic [1:0]             w_redir_hit;
  logic [1:0]             w_elig;
  logic [1:0]             w_avail;
  logic [1:0]             w_push;
  logic [1:0]             w_pop;
  logic [1:0]             w_full;
  logic [1:0]             w_empty;
  logic [1:0][CNT_W-1:0]  w_count;
  logic [1:0][DATA_W-1:0] w_head_instr;
  logic [1:0][ADDR_W-1:0] w_head_pc;
  hart_t                  w_sel;
  logic                   w_out_valid;
  hart_t                  w_pick;

  // Per-hart redirect decode, fetch eligibility and output availability.
  always_comb begin
    w_redir_hit = {redirect_valid & redirect_hart, redirect_valid & ~redirect_hart};
    for (int h = 0; h < 2; h++) begin
      w_elig[h]  = (w_count[h] < DEPTH_C) && !w_redir_hit[h];
      w_avail[h] = !w_empty[h] && !w_redir_hit[h];
    end
    w_pick = rr_pick(r_last_issue, w_elig);
  end

  // Fetch FSM next state: request bookkeeping, kill tracking and buffer push.
  always_comb begin
    w_state_nxt      = r_state;
    w_hart_nxt       = r_hart;
    w_addr_nxt       = r_addr;
    w_last_issue_nxt = r_last_issue;
    w_kill_nxt       = r_kill | ((r_state != ST_IDLE) && w_redir_hit[r_hart]);
    w_pc_inc         = 1'b0;
    w_push           = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_hart_nxt       = w_pick;
          w_addr_nxt       = r_pc[w_pick];
          w_last_issue_nxt = w_pick;
          w_kill_nxt       = 1'b0;
          w_state_nxt      = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          // A killed request already had its PC replaced by the redirect.
          w_pc_inc    = !r_kill && !w_redir_hit[r_hart];
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          // Push into a full buffer only when it drains in the same cycle.
          w_push[r_hart] = !r_kill && !w_redir_hit[r_hart] &&
                           (!w_full[r_hart] || w_pop[r_hart]);
          w_kill_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_kill_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // PC update: a redirect wins over the post-handshake increment.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      if (w_redir_hit[h]) begin
        w_pc_nxt[h] = redirect_pc;
      end else if (w_pc_inc && (r_hart == hart_t'(h))) begin
        w_pc_nxt[h] = r_pc[h] + ADDR_W'(4);
      end else begin
        w_pc_nxt[h] = r_pc[h];
      end
    end
  end

  // Output round-robin over non-empty, non-redirected buffers.
  always_comb begin
    w_sel       = rr_pick(r_last_pop, w_avail);
    w_out_valid = |w_avail;
    w_pop       = 2'b00;
    if (w_out_valid && out_ready) begin
      w_pop[w_sel] = 1'b1;
    end else begin
      w_pop = 2'b00;
    end
  end

  // Decode-side outputs, forced to zero when nothing is offered.
  always_comb begin
    out_valid = w_out_valid;
    if (w_out_valid) begin
      out_instr = w_head_instr[w_sel];
      out_pc    = w_head_pc[w_sel];
      out_hart  = w_sel;
    end else begin
      out_instr = '0;
      out_pc    = '0;
      out_hart  = 1'b0;
    end
  end

  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_req_addr  = r_addr;

  // FSM, request, PC and round-robin state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hart       <= 1'b0;
      r_addr       <= '0;
      r_kill       <= 1'b0;
      r_last_issue <= 1'b1;
      r_last_pop   <= 1'b1;
      r_pc[0]      <= RESET_PC0;
      r_pc[1]      <= RESET_PC1;
    end else begin
      r_state      <= w_state_nxt;
      r_hart       <= w_hart_nxt;
      r_addr       <= w_addr_nxt;
      r_kill       <= w_kill_nxt;
      r_last_issue <= w_last_issue_nxt;
      r_pc[0]      <= w_pc_nxt[0];
      r_pc[1]      <= w_pc_nxt[1];
      if (w_out_valid && out_ready) begin
        r_last_pop <= w_sel;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_buf
    fetch_buf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (BUF_DEPTH)
    ) u_buf (
      .clk          (clk),
      .reset        (reset),
      .i_push       (w_push[g]),
      .i_push_instr (mem_resp_data),
      .i_push_pc    (r_addr),
      .i_pop        (w_pop[g]),
      .i_flush      (w_redir_hit[g]),
      .o_head_instr (w_head_instr[g]),
      .o_head_pc    (w_head_pc[g]),
      .o_full       (w_full[g]),
      .o_empty      (w_empty[g]),
      .o_count      (w_count[g])
    );
  end

endmodule

// File: tb/tb_fetch_scheduler.sv
// Directed bench for fetch_scheduler with a small latency-programmable memory.
module tb_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic        redirect_hart;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_hart;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] req_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] hart_q[$];

  int          lat;
  logic        pend;
  int          pcnt;
  logic [31:0] paddr;

  fetch_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_hart  (redirect_hart),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_hart       (out_hart)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (i < req_q.size()) ? req_q[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] pc_at(input int i);
    return (i < pc_q.size()) ? pc_q[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] instr_at(input int i);
    return (i < instr_q.size()) ? instr_q[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] hart_at(input int i);
    return (i < hart_q.size()) ? hart_q[i] : 32'hFFFF_FFFF;
  endfunction

  // One clock: log handshakes/pops before the edge, then drive the memory model.
  task automatic cycle();
    logic        hs;
    logic [31:0] a;
    hs = mem_req_valid && mem_req_ready;
    a  = mem_req_addr;
    if (hs) req_q.push_back(a);
    if (out_valid && out_ready) begin
      pc_q.push_back(out_pc);
      instr_q.push_back(out_instr);
      hart_q.push_back({31'd0, out_hart});
    end
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    if (hs) begin
      pend  = 1'b1;
      pcnt  = lat;
      paddr = a;
    end
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = paddr ^ 32'hDEAD_0000;
        pend           = 1'b0;
      end
    end
  endtask

  task automatic wait_reqs(input int n, input string tag);
    for (int i = 0; i < 200 && req_q.size() < n; i++) cycle();
    check_eq(tag, req_q.size(), n);
  endtask

  task automatic wait_pops(input int n, input string tag);
    for (int i = 0; i < 200 && pc_q.size() < n; i++) cycle();
    check_eq(tag, (pc_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    check_eq({tag, "_req_addr"},  mem_req_addr, 32'd0);
    check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_out_instr"}, out_instr, 32'd0);
    check_eq({tag, "_out_pc"},    out_pc, 32'd0);
    check_eq({tag, "_out_hart"},  {31'd0, out_hart}, 32'd0);
  endtask

  // Hold reset for two edges with quiet inputs, then release just after an edge.
  task automatic do_reset(input bit check_in_reset);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_hart  = 1'b0;
    redirect_pc    = 32'd0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'd0;
    out_ready      = 1'b1;
    pend           = 1'b0;
    pcnt           = 0;
    lat            = 1;
    req_q.delete(); pc_q.delete(); instr_q.delete(); hart_q.delete();
    repeat (2) @(posedge clk);
    #1;
    if (check_in_reset) check_outputs_zero("rst");
    reset = 1'b0;
  endtask

  initial begin
    // Test 1: alternating fetch and drain.
    do_reset(1'b1);
    check_eq("t1_valid_at_release", {31'd0, mem_req_valid}, 32'd0);
    cycle();
    check_eq("t1_first_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("t1_first_req_addr", mem_req_addr, 32'h0000_0000);
    wait_reqs(4, "t1_nreq");
    check_eq("t1_req0", req_at(0), 32'h0000_0000);
    check_eq("t1_req1", req_at(1), 32'h0000_1000);
    check_eq("t1_req2", req_at(2), 32'h0000_0004);
    check_eq("t1_req3", req_at(3), 32'h0000_1004);
    wait_pops(4, "t1_npop");
    check_eq("t1_hart0", hart_at(0), 32'd0);
    check_eq("t1_hart1", hart_at(1), 32'd1);
    check_eq("t1_hart2", hart_at(2), 32'd0);
    check_eq("t1_hart3", hart_at(3), 32'd1);
    check_eq("t1_pc0", pc_at(0), 32'h0000_0000);
    check_eq("t1_pc1", pc_at(1), 32'h0000_1000);
    check_eq("t1_pc2", pc_at(2), 32'h0000_0004);
    check_eq("t1_pc3", pc_at(3), 32'h0000_1004);
    check_eq("t1_instr0", instr_at(0), 32'hDEAD_0000);
    check_eq("t1_instr1", instr_at(1), 32'hDEAD_1000);

    // Test 2: decode stalled, both buffers fill and fetch stops.
    do_reset(1'b0);
    out_ready = 1'b0;
    repeat (20) cycle();
    check_eq("t2_nreq", req_q.size(), 32'd4);
    check_eq("t2_req_valid_low", {31'd0, mem_req_valid}, 32'd0);
    check_eq("t2_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t2_out_pc", out_pc, 32'h0000_0000);
    out_ready = 1'b1;
    wait_reqs(6, "t2_nreq_after");
    check_eq("t2_req4_pc0_plus8", req_at(4), 32'h0000_0008);
    check_eq("t2_req5_pc1_plus8", req_at(5), 32'h0000_1008);
    wait_pops(4, "t2_npop");
    check_eq("t2_pop1", pc_at(1), 32'h0000_1000);
    check_eq("t2_pop3", pc_at(3), 32'h0000_1004);

    // Test 3: redirect hart 0 while its fetch waits for memory.
    do_reset(1'b0);
    out_ready = 1'b0;
    lat       = 3;
    wait_reqs(3, "t3_nreq_pre");
    check_eq("t3_inflight_addr", req_at(2), 32'h0000_0004);
    redirect_valid = 1'b1;
    redirect_hart  = 1'b0;
    redirect_pc    = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    repeat (40) cycle();
    check_eq("t3_nreq", req_q.size(), 32'd6);
    check_eq("t3_req3", req_at(3), 32'h0000_1004);
    check_eq("t3_req4", req_at(4), 32'h0000_0200);
    check_eq("t3_req5", req_at(5), 32'h0000_0204);
    out_ready = 1'b1;
    wait_pops(4, "t3_npop");
    check_eq("t3_pop0_pc", pc_at(0), 32'h0000_0200);
    check_eq("t3_pop0_instr", instr_at(0), 32'hDEAD_0200);
    check_eq("t3_pop1_pc", pc_at(1), 32'h0000_1000);
    check_eq("t3_pop1_instr", instr_at(1), 32'hDEAD_1000);
    check_eq("t3_pop2_pc", pc_at(2), 32'h0000_0204);
    check_eq("t3_pop3_pc", pc_at(3), 32'h0000_1004);

    // Test 4: request stall with a redirect in the middle.
    do_reset(1'b0);
    mem_req_ready = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_stall_valid", {31'd0, mem_req_valid}, 32'd1);
      check_eq("t4_stall_addr", mem_req_addr, 32'h0000_0000);
      if (i == 2) begin
        redirect_valid = 1'b1;
        redirect_hart  = 1'b0;
        redirect_pc    = 32'h0000_0300;
      end
      cycle();
      redirect_valid = 1'b0;
    end
    check_eq("t4_hold_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("t4_hold_addr", mem_req_addr, 32'h0000_0000);
    mem_req_ready = 1'b1;
    wait_reqs(3, "t4_nreq");
    check_eq("t4_req0", req_at(0), 32'h0000_0000);
    check_eq("t4_req1", req_at(1), 32'h0000_1000);
    check_eq("t4_req2_redirect_pc", req_at(2), 32'h0000_0300);
    wait_pops(2, "t4_npop");
    check_eq("t4_pop0_pc", pc_at(0), 32'h0000_1000);
    check_eq("t4_pop0_hart", hart_at(0), 32'd1);
    check_eq("t4_pop1_pc", pc_at(1), 32'h0000_0300);
    check_eq("t4_pop1_instr", instr_at(1), 32'hDEAD_0300);

    // Test 5: reset in WAIT, stray response afterwards.
    do_reset(1'b0);
    out_ready = 1'b0;
    lat       = 3;
    wait_reqs(3, "t5_nreq_pre");
    check_eq("t5_buffered_before", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    pend  = 1'b0;
    #1;
    check_outputs_zero("t5_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_q.delete(); pc_q.delete(); instr_q.delete(); hart_q.delete();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_BAD0;
    cycle();
    check_eq("t5_stray_ignored", {31'd0, out_valid}, 32'd0);
    check_eq("t5_req_after_release", {31'd0, mem_req_valid}, 32'd1);
    wait_reqs(1, "t5_nreq");
    check_eq("t5_req0", req_at(0), 32'h0000_0000);
    out_ready = 1'b1;
    wait_pops(1, "t5_npop");
    check_eq("t5_pop0_pc", pc_at(0), 32'h0000_0000);
    check_eq("t5_pop0_instr", instr_at(0), 32'hDEAD_0000);
    check_eq("t5_pop0_hart", hart_at(0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_scheduler.md
# fetch_scheduler

Two-hart instruction-fetch scheduler that shares one instruction-memory port between hart 0 and hart 1. It holds a PC per hart and issues fetch requests round-robin, with at most one request outstanding. Returned words go into a small per-hart buffer, and the buffers are drained round-robin to the decode stage, tagged with PC and hart id. It sits upstream of the instruction-selection arbiter and the decode stage, and applies branch redirects per hart.

## Interface
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction width
- RESET_PC0, 32'h0000_0000, hart 0 PC after reset
- RESET_PC1, 32'h0000_1000, hart 1 PC after reset
- BUF_DEPTH, 2, entries per hart buffer (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  branch/jump redirect strobe
- redirect_hart  in  1  hart being redirected
- redirect_pc  in  ADDR_W  new PC (word aligned)
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  fetch address
- mem_resp_valid  in  1  response strobe, in order, ≥1 cycle after request handshake
- mem_resp_data  in  DATA_W  fetched word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes
- out_instr  out  DATA_W  instruction
- out_pc  out  ADDR_W  its PC
- out_hart  out  1  its hart id

## Operation
- Fetch FSM:
  - IDLE: choose an eligible hart. A hart is eligible when its buffer occupancy is < BUF_DEPTH and no redirect for it is asserted this cycle. Prefer the hart after the last issued one. If one or more harts are eligible, latch hart id and PC, then go to REQ.
  - REQ: mem_req_valid=1 with the latched addr. On handshake, go to WAIT. PC[hart] += 4, unless a redirect for that hart is asserted in the same cycle; in that case the redirect value wins.
  - WAIT: on mem_resp_valid, push {data, latched pc} into the hart's buffer unless the request is killed, then go to IDLE.
- Redirect:
  - Sets PC[redirect_hart] = redirect_pc.
  - Flushes that hart's buffer.
  - If the in-flight request (REQ or WAIT) belongs to that hart, it is marked killed and its response is dropped.
  - Once mem_req_valid is raised, it is held with a stable addr until the handshake, even if the request is killed.
- Output:
  - out_* come combinationally from the head of the selected buffer.
  - Selection is round-robin over non-empty buffers, preferring the hart after the last one popped.
  - A pop happens on out_valid && out_ready.
  - A hart whose redirect is asserted this cycle is masked from output selection.
- Counters: occupancy is 0..BUF_DEPTH. Pointers wrap modulo BUF_DEPTH. PC increment wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE; kill flag cleared.
  - Buffers empty.
  - PC0=RESET_PC0, PC1=RESET_PC1.
  - Both round-robin pointers favour hart 0.
- First mem_req_valid appears 1 cycle after reset release (IDLE→REQ).
- Throughput is one fetch per 2 cycles + memory latency. The next IDLE decision is made in the cycle after the response.
- Response push is visible at the output on the cycle after mem_resp_valid.
- Push and pop on the same buffer in the same cycle: both happen, occupancy unchanged. This is legal when the buffer is full.
- Redirect and push for the same hart in the same cycle: the push is dropped and the buffer ends empty.
- Redirect, pop and flush of the same hart in the same cycle: no pop occurs, because the output is masked.
- mem_resp_valid outside WAIT is ignored.
- Reset asserted mid-transaction: the state is abandoned immediately. Any later stray response is ignored because the FSM is in IDLE.

## Structure
- Package fetch_pkg holds:
  - the FSM state enum (IDLE, REQ, WAIT);
  - hart id typedef;
  - default reset PC constants.
- Sub-module fetch_buf: a BUF_DEPTH FIFO of {instr, pc} with push, pop, flush, full, empty and count. It is instantiated once per hart.

## Test plan
- Reset release, mem_req_ready=1, latency 1, out_ready=1:
  - Requests alternate 0x0, 0x1000, 0x4, 0x1004.
  - Outputs are tagged hart 0, 1, 0, 1 with matching PCs.
- out_ready=0 for 20 cycles:
  - Each buffer fills to 2.
  - mem_req_valid stays low once both buffers are full.
  - Each hart's PC advances by exactly 8.
- Redirect hart 0 to 0x200 while a hart-0 request is in WAIT:
  - The response is discarded and the hart-0 buffer is flushed.
  - The next hart-0 request is to 0x200.
  - Hart-1 entries are undisturbed.
- mem_req_ready low for 5 cycles during REQ, with a redirect mid-stall:
  - mem_req_addr stays stable and valid is held.
  - The response is killed.
  - PC equals the redirect value, not value+4.
- Reset asserted in WAIT, then a stray mem_resp_valid:
  - All outputs return to 0 and buffers are empty.
  - The stray response is ignored.
  - The first request after release is again 0x0.
